mcpu_gen: RTL

Parametrised multi-cycle microprocessor core, the next generation of the lab MCPU. Word width, register count and address space are generics. The core adds subtract, shift, zero-branch and halt operations, and talks to an external synchronous single-port RAM that holds both program and data. A debug read port lets benches inspect the register file without hierarchical references.

---
 rtl/mcpu_gen_if.sv | 19 +
 rtl/mcpu_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_gen_if.sv
// mcpu_gen_if: memory bus between the mcpu_gen core and its synchronous
// single-port RAM (program and data share one address space).
//   mem_addr  : RAM address, driven by the core
//   mem_we    : RAM write enable, driven by the core
//   mem_wdata : RAM write data, driven by the core
//   mem_rdata : RAM read data, mem[mem_addr] registered at the clock edge
// Modports: master = core side, slave = RAM side.
interface mcpu_gen_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8
);
    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport master (output mem_addr, mem_we, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_we, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mcpu_gen.sv
// mcpu_gen: parametrised multi-cycle microprocessor core.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   mem      : memory bus (mcpu_gen_if master): mem_addr/mem_we/mem_wdata out,
//              mem_rdata in
//   pc       : program counter
//   halted   : core stopped by HALT
//   dbg_sel  : debug register select
//   dbg_data : combinational R[dbg_sel]
//
// state  | meaning
// -------+---------------------------------------------------
// FETCH  | present pc to RAM
// DECODE | latch instruction from RAM, increment pc
// EXEC   | ALU write / store / branch, or issue load address
// WB     | write load data into R[d]
// HALT   | terminal; only reset leaves
module mcpu_gen #(
    parameter int WORD_SIZE    = 16,
    parameter int OPCODE_SIZE  = 4,
    parameter int OPERAND_SIZE = 4,
    parameter int ADDR_SIZE    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    mcpu_gen_if.master              mem,
    output logic [ADDR_SIZE-1:0]    pc,
    output logic                    halted,
    input  logic [OPERAND_SIZE-1:0] dbg_sel,
    output logic [WORD_SIZE-1:0]    dbg_data
);
    localparam int IMM  = WORD_SIZE - OPCODE_SIZE - OPERAND_SIZE;
    localparam int NREG = 2 ** OPERAND_SIZE;
    localparam int SHW  = $clog2(WORD_SIZE);

    localparam logic [OPCODE_SIZE-1:0] OP_SHORT = OPCODE_SIZE'(0);
    localparam logic [OPCODE_SIZE-1:0] OP_LOAD  = OPCODE_SIZE'(1);
    localparam logic [OPCODE_SIZE-1:0] OP_STORE = OPCODE_SIZE'(2);
    localparam logic [OPCODE_SIZE-1:0] OP_ADD   = OPCODE_SIZE'(3);
    localparam logic [OPCODE_SIZE-1:0] OP_SUB   = OPCODE_SIZE'(4);
    localparam logic [OPCODE_SIZE-1:0] OP_AND   = OPCODE_SIZE'(5);
    localparam logic [OPCODE_SIZE-1:0] OP_OR    = OPCODE_SIZE'(6);
    localparam logic [OPCODE_SIZE-1:0] OP_XOR   = OPCODE_SIZE'(7);
    localparam logic [OPCODE_SIZE-1:0] OP_MOV   = OPCODE_SIZE'(8);
    localparam logic [OPCODE_SIZE-1:0] OP_BNZ   = OPCODE_SIZE'(9);
    localparam logic [OPCODE_SIZE-1:0] OP_BZ    = OPCODE_SIZE'(10);
    localparam logic [OPCODE_SIZE-1:0] OP_SHL   = OPCODE_SIZE'(11);
    localparam logic [OPCODE_SIZE-1:0] OP_SHR   = OPCODE_SIZE'(12);
    localparam logic [OPCODE_SIZE-1:0] OP_HALT  = OPCODE_SIZE'(15);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [WORD_SIZE-1:0] ir;
    logic [WORD_SIZE-1:0] rf [NREG];

    logic [OPCODE_SIZE-1:0]  op;
    logic [OPERAND_SIZE-1:0] rd, rs1, rs2;
    logic [IMM-1:0]          imm;
    logic [ADDR_SIZE-1:0]    imm_addr;
    logic [WORD_SIZE-1:0]    val_d, val_s1, val_s2;

    logic                 ir_load;
    logic                 pc_load;
    logic                 rf_we;
    logic [WORD_SIZE-1:0] rf_wdata;
    logic [ADDR_SIZE-1:0] mem_addr_c;
    logic                 mem_we_c;
    logic [WORD_SIZE-1:0] mem_wdata_c;

    assign op       = ir[WORD_SIZE-1 -: OPCODE_SIZE];
    assign rd       = ir[IMM +: OPERAND_SIZE];
    assign imm      = ir[IMM-1:0];
    assign rs1      = imm[IMM-1 -: OPERAND_SIZE];
    assign rs2      = imm[OPERAND_SIZE-1:0];
    assign imm_addr = imm[ADDR_SIZE-1:0];

    assign val_d    = rf[rd];
    assign val_s1   = rf[rs1];
    assign val_s2   = rf[rs2];
    assign dbg_data = rf[dbg_sel];

    assign mem.mem_addr  = mem_addr_c;
    assign mem.mem_we    = mem_we_c;
    assign mem.mem_wdata = mem_wdata_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus signals are decoded purely from state and ir, so an asynchronous
    // reset drops mem_we and returns mem_addr to pc (0) within the same cycle.
    always_comb begin
        state_nxt   = state;
        ir_load     = 1'b0;
        pc_load     = 1'b0;
        rf_we       = 1'b0;
        rf_wdata    = '0;
        mem_addr_c  = pc;
        mem_we_c    = 1'b0;
        mem_wdata_c = '0;
        halted      = 1'b0;
        case (state)
            S_FETCH: begin
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ir_load   = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (op)
                    OP_SHORT: begin
                        rf_we    = 1'b1;
                        rf_wdata = WORD_SIZE'(imm);
                    end
                    OP_LOAD: begin
                        mem_addr_c = imm_addr;
                        state_nxt  = S_WB;
                    end
                    OP_STORE: begin
                        mem_addr_c  = imm_addr;
                        mem_we_c    = 1'b1;
                        mem_wdata_c = val_d;
                    end
                    OP_ADD: begin
                        rf_we    = 1'b1;
                        rf_wdata = val_s1 + val_s2;
                    end
                    OP_SUB: begin
                        rf_we    = 1'b1;
                        rf_wdata = val_s1 - val_s2;
                    end
                    OP_AND: begin
                        rf_we    = 1'b1;
                        rf_wdata = val_s1 & val_s2;
                    end
                    OP_OR: begin
                        rf_we    = 1'b1;
                        rf_wdata = val_s1 | val_s2;
                    end
                    OP_XOR: begin
                        rf_we    = 1'b1;
                        rf_wdata = val_s1 ^ val_s2;
                    end
                    OP_MOV: begin
                        rf_we    = 1'b1;
                        rf_wdata = val_s1;
                    end
                    OP_BNZ: begin
                        pc_load = (val_d != '0);
                    end
                    OP_BZ: begin
                        pc_load = (val_d == '0);
                    end
                    OP_SHL: begin
                        rf_we    = 1'b1;
                        rf_wdata = val_s1 << val_s2[SHW-1:0];
                    end
                    OP_SHR: begin
                        rf_we    = 1'b1;
                        rf_wdata = val_s1 >> val_s2[SHW-1:0];
                    end
                    OP_HALT: begin
                        state_nxt = S_HALT;
                    end
                    default: begin
                    end
                endcase
            end
            S_WB: begin
                rf_we     = 1'b1;
                rf_wdata  = mem.mem_rdata;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
            ir <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (ir_load) begin
                ir <= mem.mem_rdata;
                pc <= pc + ADDR_SIZE'(1);
            end else if (pc_load) begin
                pc <= imm_addr;
            end
            if (rf_we) begin
                rf[rd] <= rf_wdata;
            end
        end
    end
endmodule
